// File: rtl/gmii_rx_word_packer.sv
// gmii_rx_word_packer
//   Receive-side data-path adapter behind the GMII/RGMII adapter. Accepts
//   GMII bytes or MII nibbles qualified by rx_ce and optionally strips the
//   preamble and SFD. Packs the payload into OUT_BYTES-wide words with
//   sop/eop/err framing and keeps saturating frame and error counters.
//
// Ports
//   clock_clk      block clock
//   reset_reset_n  asynchronous active-low reset
//   mac_speed      [1]=1 selects MII nibble mode; [0] unused
//   rx_ce          sample strobe qualifying rx_dv/rx_er/rxd
//   rx_dv, rx_er   receive data valid / receive error
//   rxd            receive data (only [3:0] in MII mode)
//   out_valid      one-cycle word strobe
//   out_data       packed word, first byte in [7:0], unused lanes zero
//   out_bytes      valid byte count of the word, 1..OUT_BYTES
//   out_sop/eop    first / last word of the frame
//   out_err        frame error, meaningful with out_eop
//   frame_cnt      saturating count of frames ended (eop emitted)
//   err_cnt        saturating count of errored frames plus SFD-error drops
module gmii_rx_word_packer #(
    parameter int OUT_BYTES      = 4,
    parameter bit STRIP_PREAMBLE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                        clock_clk,
    input  logic                        reset_reset_n,
    input  logic [1:0]                  mac_speed,
    input  logic                        rx_ce,
    input  logic                        rx_dv,
    input  logic                        rx_er,
    input  logic [7:0]                  rxd,
    output logic                        out_valid,
    output logic [8*OUT_BYTES-1:0]      out_data,
    output logic [$clog2(OUT_BYTES):0]  out_bytes,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic                        out_err,
    output logic [CNT_W-1:0]            frame_cnt,
    output logic [CNT_W-1:0]            err_cnt
);

    localparam int          CW   = $clog2(OUT_BYTES) + 1;
    localparam int unsigned NB   = OUT_BYTES;
    localparam logic [CW-1:0] FULL = CW'(OUT_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t state_q, state_d, eff_state;

    logic                   mii_q;
    logic                   mii_eff;
    logic                   nib_have_q, nib_have_d;
    logic [3:0]             nib_lo_q;
    logic                   byte_ok;
    logic [7:0]             byte_val;

    logic                   push;
    logic                   frame_end;
    logic                   sfd_err;
    logic                   set_err;
    logic                   frame_start;

    logic [8*OUT_BYTES-1:0] acc_q;
    logic [CW-1:0]          acc_cnt_q;
    logic                   sop_pend_q;
    logic                   sticky_q;

    logic                   unused_speed_bit;
    assign unused_speed_bit = mac_speed[0];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Byte formation. The mode is taken live from mac_speed only on the
    // sample that leaves IDLE; afterwards the latched copy is used.
    always_comb begin
        mii_eff    = (state_q == S_IDLE) ? mac_speed[1] : mii_q;
        byte_ok    = 1'b0;
        byte_val   = rxd;
        nib_have_d = nib_have_q;
        if (rx_ce) begin
            if (!rx_dv) begin
                // Frame end or idle: an odd trailing nibble is discarded.
                nib_have_d = 1'b0;
            end else if (mii_eff) begin
                if (nib_have_q) begin
                    byte_ok    = 1'b1;
                    byte_val   = {rxd[3:0], nib_lo_q};
                    nib_have_d = 1'b0;
                end else begin
                    nib_have_d = 1'b1;
                end
            end else begin
                byte_ok = 1'b1;
            end
        end
    end

    // Next-state logic. The sample that leaves IDLE is handled as the first
    // unit of the state being entered, so decode against eff_state.
    always_comb begin
        eff_state = state_q;
        push      = 1'b0;
        frame_end = 1'b0;
        sfd_err   = 1'b0;
        set_err   = 1'b0;
        if (state_q == S_IDLE && rx_ce && rx_dv) begin
            eff_state = STRIP_PREAMBLE ? S_PREAMBLE : S_DATA;
        end
        state_d = eff_state;
        case (eff_state)
            S_PREAMBLE: begin
                if (rx_ce && !rx_dv) begin
                    state_d = S_IDLE;
                end else if (byte_ok) begin
                    if (byte_val == 8'hD5) begin
                        state_d = S_DATA;
                    end else if (byte_val != 8'h55) begin
                        state_d = S_DROP;
                        sfd_err = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_ce) begin
                    if (!rx_dv) begin
                        state_d   = S_IDLE;
                        frame_end = 1'b1;
                    end else begin
                        set_err = rx_er;
                        push    = byte_ok;
                    end
                end
            end
            S_DROP: begin
                if (rx_ce && !rx_dv) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = eff_state;
            end
        endcase
        frame_start = (state_d == S_DATA) && (state_q != S_DATA);
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mii_q      <= 1'b0;
            nib_have_q <= 1'b0;
            nib_lo_q   <= '0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            sop_pend_q <= 1'b0;
            sticky_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_err    <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            nib_have_q <= nib_have_d;
            if (rx_ce && rx_dv && !nib_have_q) begin
                nib_lo_q <= rxd[3:0];
            end
            if (state_q == S_IDLE && rx_ce && rx_dv) begin
                mii_q <= mac_speed[1];
            end

            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_err   <= 1'b0;

            if (frame_start) begin
                sop_pend_q <= 1'b1;
                sticky_q   <= 1'b0;
                acc_q      <= '0;
                acc_cnt_q  <= '0;
            end

            // Must follow frame_start so an error on the first sample sticks.
            if (set_err) begin
                sticky_q <= 1'b1;
            end

            // A full word is held back until the next byte proves it is not
            // the last one; only then is it released with eop=0.
            if (push) begin
                if (acc_cnt_q == FULL) begin
                    out_valid  <= 1'b1;
                    out_data   <= acc_q;
                    out_bytes  <= FULL;
                    out_sop    <= sop_pend_q;
                    sop_pend_q <= 1'b0;
                    acc_q      <= '0;
                    acc_q[7:0] <= byte_val;
                    acc_cnt_q  <= CW'(1);
                end else begin
                    for (int unsigned i = 0; i < NB; i++) begin
                        if (acc_cnt_q == CW'(i)) begin
                            acc_q[8*i +: 8] <= byte_val;
                        end
                    end
                    acc_cnt_q <= acc_cnt_q + 1'b1;
                end
            end

            if (frame_end) begin
                if (acc_cnt_q != '0) begin
                    out_valid <= 1'b1;
                    out_data  <= acc_q;
                    out_bytes <= acc_cnt_q;
                    out_sop   <= sop_pend_q;
                    out_eop   <= 1'b1;
                    out_err   <= sticky_q;
                    frame_cnt <= sat_inc(frame_cnt);
                    if (sticky_q) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                acc_q      <= '0;
                acc_cnt_q  <= '0;
                sop_pend_q <= 1'b0;
                sticky_q   <= 1'b0;
            end

            // Never coincides with an eop, so the two err_cnt updates are exclusive.
            if (sfd_err) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: doc/gmii_rx_word_packer.md
Name: gmii_rx_word_packer

Overview:
Receive-side MAC-facing data-path adapter that sits behind the GMII/RGMII adapter. It accepts GMII bytes (1000 Mb/s) or MII nibbles (10/100 Mb/s) qualified by a sample strobe, then strips preamble/SFD. It packs payload bytes into OUT_BYTES-wide words with sop/eop/err framing and keeps saturating frame and error counters. It is the parametrised, multi-speed successor to the fixed byte-path adapter and runs entirely on one clock.

Parameters:
OUT_BYTES, 4, output word width in bytes; legal values 1, 2, 4, 8
STRIP_PREAMBLE, 1, 1 = discard preamble and SFD; 0 = pass every byte, with sop on the first byte
CNT_W, 16, width of the statistics counters

Ports:
clock_clk  in  1  block clock
reset_reset_n  in  1  asynchronous active-low reset
mac_speed  in  2  bit1=0: GMII byte mode; bit1=1: MII nibble mode; bit0 ignored
rx_ce  in  1  sample strobe; rx_dv/rx_er/rxd are valid only when rx_ce=1
rx_dv  in  1  receive data valid
rx_er  in  1  receive error
rxd  in  8  receive data; only [3:0] is used in MII mode
out_valid  out  1  one-cycle word strobe
out_data  out  8*OUT_BYTES  packed word; first byte in [7:0]; unused lanes are 0
out_bytes  out  clog2(OUT_BYTES)+1  number of valid bytes, 1..OUT_BYTES
out_sop  out  1  first word of the frame
out_eop  out  1  last word of the frame
out_err  out  1  frame error; meaningful only with out_eop
frame_cnt  out  CNT_W  frames ended (eop emitted)
err_cnt  out  CNT_W  errored frames plus SFD-error drops

Behaviour:
- All state advances only on cycles with rx_ce=1, except output strobes and counter updates. Cycles with rx_ce=0 are ignored completely.
- Reset: every output is 0, the FSM is IDLE, and the nibble, word and sticky-error registers are cleared.
- Mode latch: mac_speed[1] is sampled only on the IDLE->active transition. A change mid-frame takes effect at the next frame.
- Byte formation, MII mode: the low nibble arrives first, and a byte is formed from every two dv nibbles.
- Byte formation, GMII mode: each dv sample is one byte.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE: on rx_dv=1, go to PREAMBLE (STRIP_PREAMBLE=1) or DATA (STRIP_PREAMBLE=0). The current sample is processed as that state's first unit.
- PREAMBLE:
  - byte 0x55: discard it.
  - byte 0xD5: go to DATA; the next byte is the first payload byte.
  - any other byte: err_cnt+1, go to DROP.
  - rx_dv=0: go to IDLE with no count.
- DATA:
  - each byte is appended to the word accumulator.
  - rx_er=1 while rx_dv=1 sets the sticky error.
  - rx_dv=0 ends the frame and returns to IDLE.
- DROP: on rx_dv=0, go to IDLE. No output is produced.
- Dribble nibble: an odd trailing nibble in MII mode is discarded and is not an error.
- Word emission rule: a full word is held until either of two events, so that eop can be attached to it.
  - The next payload byte arrives: the held word is emitted with eop=0 in the following cycle.
  - The frame ends: the held word is emitted with eop=1 in the cycle after the rx_dv=0 sample.
- Partial words are emitted only at frame end, with out_bytes = the byte count.
- out_sop=1 on the first emitted word of each frame. A single-word frame has both sop and eop set.
- Zero payload bytes (SFD immediately followed by dv=0): nothing is emitted and no counter changes.
- Framing on eop:
  - out_err = sticky error; the sticky error is cleared after eop.
  - frame_cnt+1 on every eop.
  - err_cnt+1 when out_err=1.
  - Counters saturate at all-ones. An SFD error and an eop can never occur in the same cycle.
- rx_dv=0 with rx_er=1 (carrier extension/false carrier) is treated as dv=0 and ignored.
- There is no backpressure. The output stage is 1 word deep, and throughput is at most 1 byte per rx_ce, so overflow cannot occur.
- Asynchronous reset mid-frame clears everything. Any following rx_dv=1 samples of the same frame are parsed as a new frame; with STRIP_PREAMBLE=1 they normally go to DROP on a non-0x55 byte.

Test Plan:
1. GMII, OUT_BYTES=4, rx_ce always 1, frame 55x7 D5 01..0A then dv=0 -> three words:
   - 0x04030201, sop, bytes=4
   - 0x08070605, bytes=4
   - 0x00000A09, eop, bytes=2, err=0
   - frame_cnt=1
2. MII, rx_ce every 10th cycle, nibbles 5x15 D then bytes 11 22 33 44 (low nibble first) -> one word 0x44332211, sop=eop=1, bytes=4. Add a dribble nibble after the last byte -> identical output.
3. GMII, rx_er=1 on the third payload byte of an 8-byte frame -> second word has eop=1, err=1; err_cnt=1, frame_cnt=1.
4. GMII, preamble 55 55 AB ... -> no output, err_cnt=1. A following valid frame is delivered normally.
5. Boundaries:
   - SFD then immediate dv=0 -> no output, counters unchanged.
   - Toggle mac_speed mid-frame -> frame is completed in the latched mode.
   - STRIP_PREAMBLE=0 -> 0x55 bytes appear in word 0 with sop.
6. Saturation with CNT_W=4 -> frame_cnt holds at 15 after 20 frames. Reset asserted mid-frame -> all outputs 0 immediately.
